// File: rtl/picoblaze_io_hub_pkg.sv
// Shared definitions for the PicoBlaze I/O hub: port map, CTRL bit positions
// and the interrupt handshake state type.
package picoblaze_io_hub_pkg;

    localparam logic [7:0] ADDR_IN_BASE  = 8'h00;
    localparam logic [7:0] ADDR_OUT_BASE = 8'h80;
    localparam logic [7:0] ADDR_STATUS   = 8'hF0;
    localparam logic [7:0] ADDR_MASK     = 8'hF1;
    localparam logic [7:0] ADDR_CTRL     = 8'hF2;
    localparam logic [7:0] ADDR_PER_LO   = 8'hF3;
    localparam logic [7:0] ADDR_PER_HI   = 8'hF4;
    localparam logic [7:0] ADDR_TSTAT    = 8'hF5;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_AUTORELOAD_BIT = 1;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [7:0] bank_addr(input logic [7:0] base, input int idx);
        return base + 8'(idx);
    endfunction

endpackage

// File: rtl/picoblaze_interval_timer.sv
// Programmable interval timer: prescaler, 16-bit down-counter, reload and
// one-shot handling. expire is a single-cycle pulse on every firing.
module picoblaze_interval_timer
    import picoblaze_io_hub_pkg::*;
#(
    parameter int PRESCALE = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_wr,
    input  logic        per_lo_wr,
    input  logic        per_hi_wr,
    input  logic [7:0]  wdata,
    output logic        enable,
    output logic        autoreload,
    output logic [15:0] period,
    output logic        expire
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic            enable_q, enable_d;
    logic            autoreload_q, autoreload_d;
    logic [15:0]     period_q, period_d;
    logic [15:0]     count_q, count_d;
    logic [PS_W-1:0] prescale_q, prescale_d;
    logic            start_q, start_d;
    logic            tick;
    logic            fire;

    // start_q marks the cycle right after an enabling CTRL write; the timer
    // fires there and the prescaler is held so each period is exact.
    always_comb begin
        enable_d     = enable_q;
        autoreload_d = autoreload_q;
        period_d     = period_q;
        count_d      = count_q;
        start_d      = 1'b0;

        tick = enable_q && !start_q && (prescale_q == PS_LAST);
        fire = enable_q && (period_q != 16'd0)
               && (start_q || (tick && (count_q == 16'd0)));

        if (!enable_q || start_q || tick) begin
            prescale_d = '0;
        end else begin
            prescale_d = prescale_q + 1'b1;
        end

        if (fire) begin
            count_d = period_q - 16'd1;
            if (!autoreload_q) begin
                enable_d = 1'b0;
            end
        end else if (tick && (count_q != 16'd0)) begin
            count_d = count_q - 16'd1;
        end

        if (per_lo_wr) begin
            period_d[7:0] = wdata;
        end
        if (per_hi_wr) begin
            period_d[15:8] = wdata;
        end

        if (ctrl_wr) begin
            enable_d     = wdata[CTRL_ENABLE_BIT];
            autoreload_d = wdata[CTRL_AUTORELOAD_BIT];
            start_d      = wdata[CTRL_ENABLE_BIT];
            prescale_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q     <= 1'b0;
            autoreload_q <= 1'b0;
            period_q     <= 16'd0;
            count_q      <= 16'd0;
            prescale_q   <= '0;
            start_q      <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            autoreload_q <= autoreload_d;
            period_q     <= period_d;
            count_q      <= count_d;
            prescale_q   <= prescale_d;
            start_q      <= start_d;
        end
    end

    assign enable     = enable_q;
    assign autoreload = autoreload_q;
    assign period     = period_q;
    assign expire     = fire;

endmodule

// File: rtl/picoblaze_io_hub.sv
// PicoBlaze (pacoblaze3) I/O hub: GPI/GPO banks, registered read mux, and a
// masked, latched interrupt controller with an internal interval timer.
module picoblaze_io_hub
    import picoblaze_io_hub_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int TICK_HZ     = 1000,
    parameter int NUM_IN      = 2,
    parameter int NUM_OUT     = 2,
    parameter int NUM_IRQ     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           port_id,
    input  logic [7:0]           out_port,
    input  logic                 write_strobe,
    input  logic                 read_strobe,
    output logic [7:0]           in_port,
    output logic                 interrupt,
    input  logic                 interrupt_ack,
    input  logic [8*NUM_IN-1:0]  gpi,
    output logic [8*NUM_OUT-1:0] gpo,
    input  logic [NUM_IRQ-1:0]   irq_src
);

    localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW       = NUM_IRQ + 1;

    logic [7:0]           in_port_q, in_port_d;
    logic [8*NUM_OUT-1:0] gpo_q, gpo_d;
    logic [PW-1:0]        pending_q, pending_d;
    logic [PW-1:0]        mask_q, mask_d;
    logic [PW-1:0]        w1c;
    logic                 expired_q, expired_d;
    logic [NUM_IRQ-1:0]   sync1_q, sync1_d;
    logic [NUM_IRQ-1:0]   sync2_q, sync2_d;
    logic [NUM_IRQ-1:0]   prev_q, prev_d;
    logic [NUM_IRQ-1:0]   irq_edge;
    irq_state_e           state_q, state_d;

    logic        wr_status, wr_mask, wr_ctrl, wr_per_lo, wr_per_hi, rd_tstat;
    logic        tmr_enable, tmr_autoreload, tmr_expire;
    logic [15:0] tmr_period;

    assign wr_status = write_strobe && (port_id == ADDR_STATUS);
    assign wr_mask   = write_strobe && (port_id == ADDR_MASK);
    assign wr_ctrl   = write_strobe && (port_id == ADDR_CTRL);
    assign wr_per_lo = write_strobe && (port_id == ADDR_PER_LO);
    assign wr_per_hi = write_strobe && (port_id == ADDR_PER_HI);
    assign rd_tstat  = read_strobe && (port_id == ADDR_TSTAT);

    picoblaze_interval_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .ctrl_wr    (wr_ctrl),
        .per_lo_wr  (wr_per_lo),
        .per_hi_wr  (wr_per_hi),
        .wdata      (out_port),
        .enable     (tmr_enable),
        .autoreload (tmr_autoreload),
        .period     (tmr_period),
        .expire     (tmr_expire)
    );

    // Unmapped addresses read as zero so in_port never carries x.
    always_comb begin
        case (port_id)
            ADDR_STATUS: in_port_d = 8'(pending_q);
            ADDR_MASK:   in_port_d = 8'(mask_q);
            ADDR_CTRL:   in_port_d = {6'b0, tmr_autoreload, tmr_enable};
            ADDR_PER_LO: in_port_d = tmr_period[7:0];
            ADDR_PER_HI: in_port_d = tmr_period[15:8];
            ADDR_TSTAT:  in_port_d = {7'b0, expired_q};
            default:     in_port_d = 8'h00;
        endcase
        for (int i = 0; i < NUM_IN; i++) begin
            if (port_id == bank_addr(ADDR_IN_BASE, i)) begin
                in_port_d = gpi[8*i +: 8];
            end
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            if (port_id == bank_addr(ADDR_OUT_BASE, i)) begin
                in_port_d = gpo_q[8*i +: 8];
            end
        end
    end

    // A new edge in the same cycle as a W1C of that bit keeps the bit set.
    always_comb begin
        gpo_d = gpo_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (write_strobe && (port_id == bank_addr(ADDR_OUT_BASE, i))) begin
                gpo_d[8*i +: 8] = out_port;
            end
        end

        mask_d = wr_mask ? out_port[PW-1:0] : mask_q;
        w1c    = wr_status ? out_port[PW-1:0] : '0;

        sync1_d  = irq_src;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        irq_edge = sync2_q & ~prev_q;

        pending_d = (pending_q & ~w1c) | {tmr_expire, irq_edge};

        expired_d = expired_q;
        if (rd_tstat) begin
            expired_d = 1'b0;
        end
        if (tmr_expire) begin
            expired_d = 1'b1;
        end
    end

    // Request on masked pending, hold until ack, then stay in service until
    // the EOI write so the same source cannot re-interrupt the handler.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE: begin
                if ((|(pending_d & mask_d)) && !interrupt_ack) begin
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (interrupt_ack) begin
                    state_d = IRQ_SERVICE;
                end
            end
            IRQ_SERVICE: begin
                if (wr_status) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_port_q <= 8'h00;
            gpo_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            expired_q <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            state_q   <= IRQ_IDLE;
        end else begin
            in_port_q <= in_port_d;
            gpo_q     <= gpo_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            expired_q <= expired_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
        end
    end

    assign in_port   = in_port_q;
    assign gpo       = gpo_q;
    assign interrupt = (state_q == IRQ_REQ);

endmodule
